// File: rtl/frame_buffer_ctrl.sv
// Triple-buffer rotation controller: hands the writer and the display reader
// distinct DDR frame buffers and tracks dropped and repeated frames.
module frame_buffer_ctrl #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter logic [31:0] FRAME_STRIDE = 32'h0004_0000
) (
    input  logic        clk_100Mhz,
    input  logic        rst,
    input  logic        enable,
    input  logic        writer_done,
    input  logic        rd_frame_start,
    output logic [31:0] wr_base_addr,
    output logic [31:0] rd_base_addr,
    output logic [1:0]  wr_idx,
    output logic [1:0]  rd_idx,
    output logic        rd_frame_valid,
    output logic [15:0] drop_cnt,
    output logic [15:0] repeat_cnt,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t     state_q;
    logic       ready_valid;
    logic       wd_d1;
    logic       fs_d1;
    logic       wd_p;
    logic       fs_p;
    logic [1:0] ready_idx;

    assign wd_p      = writer_done & ~wd_d1;
    assign fs_p      = rd_frame_start & ~fs_d1;
    // The three indices always form a permutation of {0,1,2}.
    assign ready_idx = 2'd3 - wr_idx - rd_idx;
    assign state     = state_q;

    function automatic logic [31:0] slot_addr(input logic [1:0] idx);
        return BASE_ADDR + FRAME_STRIDE * 32'(idx);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            state_q        <= S_INIT;
            wr_idx         <= 2'd0;
            rd_idx         <= 2'd1;
            ready_valid    <= 1'b0;
            rd_frame_valid <= 1'b0;
            drop_cnt       <= 16'd0;
            repeat_cnt     <= 16'd0;
            wd_d1          <= 1'b0;
            fs_d1          <= 1'b0;
            wr_base_addr   <= slot_addr(2'd0);
            rd_base_addr   <= slot_addr(2'd1);
        end else begin
            wd_d1 <= writer_done;
            fs_d1 <= rd_frame_start;
            // Disabled, initialising or illegal encoding: park on init indices.
            if (!enable || (state_q != S_FILL && state_q != S_RUN)) begin
                state_q        <= (enable && state_q == S_INIT) ? S_FILL : S_INIT;
                wr_idx         <= 2'd0;
                rd_idx         <= 2'd1;
                ready_valid    <= 1'b0;
                rd_frame_valid <= 1'b0;
                wr_base_addr   <= slot_addr(2'd0);
                rd_base_addr   <= slot_addr(2'd1);
            end else if (state_q == S_FILL) begin
                if (wd_p) begin
                    wr_idx       <= ready_idx;
                    wr_base_addr <= slot_addr(ready_idx);
                    ready_valid  <= 1'b1;
                    state_q      <= S_RUN;
                end
            end else begin
                case ({wd_p, fs_p})
                    2'b10: begin
                        wr_idx       <= ready_idx;
                        wr_base_addr <= slot_addr(ready_idx);
                        ready_valid  <= 1'b1;
                        if (ready_valid) drop_cnt <= sat_inc(drop_cnt);
                    end
                    2'b01: begin
                        if (ready_valid) begin
                            rd_idx         <= ready_idx;
                            rd_base_addr   <= slot_addr(ready_idx);
                            ready_valid    <= 1'b0;
                            rd_frame_valid <= 1'b1;
                        end else if (rd_frame_valid) begin
                            repeat_cnt <= sat_inc(repeat_cnt);
                        end
                    end
                    // Fresh frame goes straight to the reader; any waiting frame is lost.
                    2'b11: begin
                        rd_idx         <= wr_idx;
                        rd_base_addr   <= slot_addr(wr_idx);
                        wr_idx         <= ready_idx;
                        wr_base_addr   <= slot_addr(ready_idx);
                        ready_valid    <= 1'b0;
                        rd_frame_valid <= 1'b1;
                        if (ready_valid) drop_cnt <= sat_inc(drop_cnt);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/frame_buffer_ctrl.md
FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000: DDR address of buffer 0.
REQ-002 SHALL have parameter FRAME_STRIDE, default 32'h0004_0000: byte spacing between buffers, at least one 320x240x16b frame.
REQ-003 SHALL have port clk_100Mhz, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: level; 1 = buffer rotation active.
REQ-006 SHALL have port writer_done, input, 1 bit: writer frame complete; level or pulse, rising edge detected internally.
REQ-007 SHALL have port rd_frame_start, input, 1 bit: display reader frame start (vsync); rising edge detected internally.
REQ-008 SHALL have port wr_base_addr, output, 32 bits: FRAME_BASE_ADDR for the writer.
REQ-009 SHALL have port rd_base_addr, output, 32 bits: base address for the display reader.
REQ-010 SHALL have ports wr_idx and rd_idx, output, 2 bits each: current buffer indices, range 0..2.
REQ-011 SHALL have port rd_frame_valid, output, 1 bit: reader buffer holds a completed frame.
REQ-012 SHALL have ports drop_cnt and repeat_cnt, output, 16 bits each: saturating statistics.
REQ-013 SHALL have port state, output, 2 bits: FSM state, for debug.

Function
REQ-014 SHALL manage three buffers; buffer k base = BASE_ADDR + k*FRAME_STRIDE; arithmetic is 32-bit, overflow wraps.
REQ-015 SHALL keep wr_idx != rd_idx at all times; ready slot is implicit: ready_idx = 3 - wr_idx - rd_idx.
REQ-016 SHALL keep an internal ready_valid flag: 1 when ready slot holds a completed, unread frame.
REQ-017 SHALL form edge pulses as wd_p = writer_done & ~writer_done_d1 and fs_p = rd_frame_start & ~rd_frame_start_d1.
REQ-018 SHALL update all outputs on the same clock edge that samples the pulse; latency is 1 clock from input rise.
REQ-019 SHALL implement states S_INIT=0, S_FILL=1, S_RUN=2; encoding 3 is unused and SHALL go to S_INIT.
REQ-020 In S_INIT: wr_idx=0, rd_idx=1, ready_valid=0, rd_frame_valid=0; enable=1 -> S_FILL.
REQ-021 In S_FILL: pulses ignored except wd_p; on wd_p: ready_idx<-old wr_idx, ready_valid=1, wr_idx<-2, rd_idx unchanged; -> S_RUN.
REQ-022 In S_RUN, wd_p only: wr_idx<-old ready_idx; ready_valid=1; if ready_valid was already 1, drop_cnt+1 (overwritten unread frame).
REQ-023 In S_RUN, fs_p only, ready_valid=1: rd_idx<-ready_idx; ready_valid=0; rd_frame_valid=1.
REQ-024 In S_RUN, fs_p only, ready_valid=0: rd_idx unchanged; repeat_cnt+1 if rd_frame_valid=1.
REQ-025 In S_RUN, wd_p and fs_p in same cycle: rd_idx<-old wr_idx; wr_idx<-3-old wr_idx-old rd_idx; ready_valid=0; rd_frame_valid=1; drop_cnt+1 if ready_valid was 1.
REQ-026 SHALL saturate drop_cnt and repeat_cnt at 16'hFFFF; no wrap.
REQ-027 enable=0 in any state SHALL return the FSM to S_INIT on the next edge with S_INIT index values; counters hold.
REQ-028 SHALL register wr_base_addr and rd_base_addr, consistent with wr_idx and rd_idx in the same cycle.
REQ-029 Writer address changes only on the wd_p cycle; reader address changes only on a fs_p cycle.

Reset
REQ-030 On rst=1 at a clock edge: state=S_INIT, wr_idx=0, rd_idx=1, ready_valid=0, rd_frame_valid=0, drop_cnt=0, repeat_cnt=0, edge-detect registers=0, wr_base_addr=BASE_ADDR, rd_base_addr=BASE_ADDR+FRAME_STRIDE.
REQ-031 rst SHALL take priority over enable, wd_p and fs_p; reset mid-frame discards ready_valid with no counter update.

Verification
REQ-032 Reset then enable=1 then writer_done pulse -> state=S_RUN, wr_idx=2, rd_idx=1, wr_base_addr=32'h1008_0000, rd_frame_valid=0.
REQ-033 Then rd_frame_start pulse -> rd_idx=0, rd_base_addr=32'h1000_0000, rd_frame_valid=1, repeat_cnt=0.
REQ-034 Two writer_done pulses with no frame start between them, in S_RUN -> drop_cnt=1; wr_idx never equals rd_idx.
REQ-035 Two frame starts with no writer_done, after first display -> repeat_cnt=2, rd_idx unchanged.
REQ-036 writer_done and rd_frame_start rising on the same edge with wr=2, rd=0 -> rd_idx=2, wr_idx=1, ready_valid=0.
REQ-037 writer_done held high for 10 cycles -> exactly one rotation; rst asserted mid-run -> all REQ-030 values on the next edge.
